// File: rtl/voter_tally.sv
// rtl/voter_tally.sv - sequential N-voter tally with one vote per voter, timeout and registered verdict
module voter_tally #(
    parameter int N_VOTERS = 4,
    parameter int TIMEOUT  = 8,
    parameter int MODE     = 0,
    localparam int CW      = $clog2(N_VOTERS + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [N_VOTERS-1:0] vote_valid,
    input  logic [N_VOTERS-1:0] vote_yes,
    output logic                busy,
    output logic                done,
    output logic [3:1]          result,
    output logic [CW-1:0]       yes_cnt,
    output logic [CW-1:0]       no_cnt
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DECIDE
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [N_VOTERS-1:0] voted;
    logic [N_VOTERS-1:0] accept;
    logic [TW-1:0]       timer;
    logic [CW-1:0]       add_yes;
    logic [CW-1:0]       add_no;
    logic                close_now;
    logic [CW:0]         yes_x2;
    logic [CW:0]         no_x2;
    logic [3:1]          verdict;

    // Only first-time voters are counted; several may land in the same cycle.
    always_comb begin
        accept  = vote_valid & ~voted;
        add_yes = '0;
        add_no  = '0;
        for (int i = 0; i < N_VOTERS; i++) begin
            add_yes = add_yes + CW'(accept[i] & vote_yes[i]);
            add_no  = add_no  + CW'(accept[i] & ~vote_yes[i]);
        end
        close_now = ((voted | accept) == {N_VOTERS{1'b1}}) ||
                    (timer == TW'(TIMEOUT - 1));
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (start) state_next = S_COLLECT;
            S_COLLECT: if (close_now) state_next = S_DECIDE;
            S_DECIDE:  state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // One extra bit so doubling a count can never wrap.
    always_comb begin
        yes_x2 = {1'b0, yes_cnt} << 1;
        no_x2  = {1'b0, no_cnt} << 1;
        if (MODE == 0) begin
            if (yes_cnt > no_cnt)      verdict = 3'b100;
            else if (no_cnt > yes_cnt) verdict = 3'b001;
            else                       verdict = 3'b010;
        end else begin
            if (yes_x2 > (CW+1)'(N_VOTERS))     verdict = 3'b100;
            else if (no_x2 > (CW+1)'(N_VOTERS)) verdict = 3'b001;
            else                                verdict = 3'b010;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            voted   <= '0;
            yes_cnt <= '0;
            no_cnt  <= '0;
            timer   <= '0;
            result  <= 3'b000;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        voted   <= '0;
                        yes_cnt <= '0;
                        no_cnt  <= '0;
                        timer   <= '0;
                    end
                end
                S_COLLECT: begin
                    voted   <= voted | accept;
                    yes_cnt <= yes_cnt + add_yes;
                    no_cnt  <= no_cnt + add_no;
                    if (!close_now) timer <= timer + TW'(1);
                end
                S_DECIDE: begin
                    result <= verdict;
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_voter_tally.sv
// tb/tb_voter_tally.sv - randomized self-checking bench for voter_tally in both counting modes
module tb_voter_tally;

    localparam int N = 4;
    localparam int T = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] vote_valid = 4'h0;
    logic [3:0] vote_yes = 4'h0;

    logic       busy0, done0, busy1, done1;
    logic [3:1] res0, res1;
    logic [2:0] yes0, no0, yes1, no1;

    voter_tally #(.N_VOTERS(N), .TIMEOUT(T), .MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .vote_valid(vote_valid), .vote_yes(vote_yes),
        .busy(busy0), .done(done0), .result(res0), .yes_cnt(yes0), .no_cnt(no0)
    );

    voter_tally #(.N_VOTERS(N), .TIMEOUT(T), .MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .vote_valid(vote_valid), .vote_yes(vote_yes),
        .busy(busy1), .done(done1), .result(res1), .yes_cnt(yes1), .no_cnt(no1)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [3:0] sv [T];
    logic [3:0] sy [T];
    logic       ss [T];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] expect_verdict(input int mode, input int y, input int n);
        if (mode == 0) begin
            if (y > n) return 3'b100;
            if (n > y) return 3'b001;
            return 3'b010;
        end
        if (2 * y > N) return 3'b100;
        if (2 * n > N) return 3'b001;
        return 3'b010;
    endfunction

    task automatic clear_plan();
        for (int c = 0; c < T; c++) begin
            sv[c] = 4'h0;
            sy[c] = 4'h0;
            ss[c] = 1'b0;
        end
    endtask

    task automatic run_session(input string name);
        logic [3:0] mv;
        int y, n, c;
        bit closed;
        mv = 4'h0;
        y = 0;
        n = 0;
        closed = 0;
        @(negedge clk);
        start      = 1'b1;
        vote_valid = 4'($urandom);
        vote_yes   = 4'($urandom);
        @(posedge clk);
        #1;
        start = 1'b0;
        for (c = 0; c < T && !closed; c++) begin
            check({name, ":busy"}, 32'(busy0 & busy1), 32'(1));
            check({name, ":done_low"}, 32'(done0 | done1), 32'(0));
            check({name, ":yes_run"}, 32'(yes0), 32'(y));
            check({name, ":no_run"}, 32'(no1), 32'(n));
            vote_valid = sv[c];
            vote_yes   = sy[c];
            start      = ss[c];
            for (int i = 0; i < N; i++) begin
                if (sv[c][i] && !mv[i]) begin
                    mv[i] = 1'b1;
                    if (sy[c][i]) y++;
                    else          n++;
                end
            end
            closed = (mv == 4'hF) || (c == T - 1);
            @(posedge clk);
            #1;
        end
        // decide cycle: inputs here must be ignored
        vote_valid = 4'($urandom);
        vote_yes   = 4'($urandom);
        start      = 1'($urandom);
        check({name, ":decide_busy"}, 32'(busy0), 32'(1));
        check({name, ":decide_done"}, 32'(done0), 32'(0));
        @(posedge clk);
        #1;
        start      = 1'b0;
        vote_valid = 4'h0;
        check({name, ":done"}, 32'(done0 & done1), 32'(1));
        check({name, ":idle_busy"}, 32'(busy0 | busy1), 32'(0));
        check({name, ":res_m0"}, 32'(res0), 32'(expect_verdict(0, y, n)));
        check({name, ":res_m1"}, 32'(res1), 32'(expect_verdict(1, y, n)));
        check({name, ":yes"}, 32'(yes0), 32'(y));
        check({name, ":no"}, 32'(no0), 32'(n));
        @(posedge clk);
        #1;
        check({name, ":done_pulse"}, 32'(done0), 32'(0));
        check({name, ":res_hold"}, 32'(res0), 32'(expect_verdict(0, y, n)));
    endtask

    initial begin
        #1;
        check("reset_busy", 32'(busy0), 32'(0));
        check("reset_done", 32'(done0), 32'(0));
        check("reset_res", 32'({res0, res1}), 32'(0));
        check("reset_cnt", 32'({yes0, no0}), 32'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        clear_plan();
        sv[0] = 4'hF; sy[0] = 4'h7;
        run_session("all_in_one");

        clear_plan();
        sv[0] = 4'h1; sy[0] = 4'h1;
        sv[1] = 4'h2; sy[1] = 4'h2;
        sv[2] = 4'h1; sy[2] = 4'h0;
        sv[3] = 4'h4; sy[3] = 4'h0;
        sv[4] = 4'h8; sy[4] = 4'h0;
        run_session("tie_repeat");

        clear_plan();
        sv[0] = 4'h1; sy[0] = 4'h1;
        run_session("timeout_one");

        clear_plan();
        run_session("timeout_none");

        clear_plan();
        sv[1] = 4'h2; sy[1] = 4'h2;
        ss[2] = 1'b1; ss[5] = 1'b1;
        run_session("ignored_start");

        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
        vote_valid = 4'h3;
        vote_yes   = 4'h1;
        @(posedge clk);
        #1;
        vote_valid = 4'h0;
        check("mid_yes", 32'(yes0), 32'(1));
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy0 | busy1), 32'(0));
        check("mid_rst_done", 32'(done0 | done1), 32'(0));
        check("mid_rst_res", 32'({res0, res1}), 32'(0));
        check("mid_rst_cnt", 32'({yes0, no0, yes1, no1}), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;

        clear_plan();
        sv[0] = 4'h6; sy[0] = 4'h0;
        sv[2] = 4'h9; sy[2] = 4'h8;
        run_session("after_reset");

        for (int s = 0; s < 40; s++) begin
            for (int c = 0; c < T; c++) begin
                sv[c] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom & $urandom);
                sy[c] = 4'($urandom);
                ss[c] = 1'($urandom);
            end
            run_session("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
